// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock, with a carry flag
// that persists between operations so rotate-through-carry can chain across words.
module shift_seq #(
    parameter int Width = 16,
    localparam int AW = $clog2(Width) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Width-1:0] A,
    input  logic [2:0]       F,
    input  logic [AW-1:0]    Amt,
    input  logic             c_load,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] Out,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             P
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [Width-1:0] w_reg;
    logic             wc_reg;
    logic [AW-1:0]    cnt_reg;
    logic [2:0]       f_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [Width-1:0] out_reg;
    logic             c_reg;
    logic             z_reg;
    logic             n_reg;
    logic             p_reg;

    logic [Width-1:0] step_w;
    logic             step_c;
    logic             commit_en;
    logic [Width-1:0] commit_w;
    logic             commit_c;
    logic             carry_start;

    // One step of the latched function applied to {wc_reg, w_reg}.
    always_comb begin
        step_w = w_reg;
        step_c = wc_reg;
        case (f_reg)
            3'b000, 3'b010: begin
                step_c = w_reg[Width-1];
                step_w = {w_reg[Width-2:0], 1'b0};
            end
            3'b001: begin
                step_c = w_reg[0];
                step_w = {1'b0, w_reg[Width-1:1]};
            end
            3'b011: begin
                step_c = w_reg[0];
                step_w = {w_reg[Width-1], w_reg[Width-1:1]};
            end
            3'b100: begin
                step_c = w_reg[Width-1];
                step_w = {w_reg[Width-2:0], w_reg[Width-1]};
            end
            3'b101: begin
                step_c = w_reg[0];
                step_w = {w_reg[0], w_reg[Width-1:1]};
            end
            3'b110: begin
                step_c = w_reg[Width-1];
                step_w = {w_reg[Width-2:0], wc_reg};
            end
            default: begin
                step_c = w_reg[0];
                step_w = {wc_reg, w_reg[Width-1:1]};
            end
        endcase
    end

    // A zero-length operation commits straight from the operands.
    always_comb begin
        carry_start = c_load ? c_in : c_reg;
        commit_en   = 1'b0;
        commit_w    = step_w;
        commit_c    = step_c;
        if (state_reg == SHIFT) begin
            commit_en = (cnt_reg == AW'(1));
        end else if (start && (Amt == '0)) begin
            commit_en = 1'b1;
            commit_w  = A;
            commit_c  = carry_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            w_reg     <= '0;
            wc_reg    <= 1'b0;
            cnt_reg   <= '0;
            f_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            out_reg   <= '0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b1;
            n_reg     <= 1'b0;
            p_reg     <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                SHIFT: begin
                    w_reg   <= step_w;
                    wc_reg  <= step_c;
                    cnt_reg <= cnt_reg - AW'(1);
                    if (commit_en) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    if (start) begin
                        w_reg   <= A;
                        f_reg   <= F;
                        cnt_reg <= Amt;
                        wc_reg  <= carry_start;
                        if (Amt == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                        end
                    end else if (c_load) begin
                        c_reg <= c_in;
                    end
                end
            endcase
            if (commit_en) begin
                out_reg <= commit_w;
                c_reg   <= commit_c;
                z_reg   <= ~|commit_w;
                n_reg   <= commit_w[Width-1];
                p_reg   <= ~^commit_w;
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Out  = out_reg;
    assign C    = c_reg;
    assign Z    = z_reg;
    assign N    = n_reg;
    assign P    = p_reg;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: table of operations with expected results, a scoreboard
// checked on every done pulse, and hand sequences for handshake and reset corners.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [2:0]  F;
    logic [4:0]  Amt;
    logic        c_load;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] Out;
    logic        C;
    logic        Z;
    logic        N;
    logic        P;

    shift_seq #(.Width(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .F(F), .Amt(Amt),
        .c_load(c_load), .c_in(c_in), .busy(busy), .done(done),
        .Out(Out), .C(C), .Z(Z), .N(N), .P(P)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] out;
        logic        c;
        logic        z;
        logic        n;
        logic        p;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]  f;
        logic [15:0] a;
        logic [4:0]  amt;
        logic        cl;
        logic        ci;
        logic [15:0] eo;
        logic        ec;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] done cycle %0d: Out=%04h C=%b Z=%b N=%b P=%b (want %04h C=%b)",
                         cyc, Out, C, Z, N, P, e.out, e.c);
                chk("out", 32'(Out), 32'(e.out));
                chk("c", 32'(C), 32'(e.c));
                chk("z", 32'(Z), 32'(e.z));
                chk("n", 32'(N), 32'(e.n));
                chk("p", 32'(P), 32'(e.p));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Caller is at a negedge: drive a start and push the expected commit.
    task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [4:0] amt,
                         input logic cl, input logic ci, input logic [15:0] eo,
                         input logic ec, output int s);
        exp_t e;
        start = 1'b1; F = f; A = a; Amt = amt; c_load = cl; c_in = ci;
        s = cyc;
        e.out = eo;
        e.c   = ec;
        e.z   = (eo == 16'h0000);
        e.n   = eo[15];
        e.p   = ~^eo;
        e.cyc = s + int'(amt) + 1;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int s, input logic [4:0] amt, input bit disturb);
        for (int k = 0; k < int'(amt) + 4 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (disturb && cyc >= s + 3 && cyc <= s + 5) begin
                start = 1'b1; A = 16'hFFFF; F = 3'b001; Amt = 5'd3;
                c_load = 1'b1; c_in = 1'b0;
            end else begin
                start = 1'b0; c_load = 1'b0;
            end
            #1;
            chk("busy", 32'(busy), 32'(cyc <= s + int'(amt)));
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [4:0] amt,
                          input logic cl, input logic ci, input logic [15:0] eo,
                          input logic ec, input bit disturb);
        int s;
        @(negedge clk);
        issue(f, a, amt, cl, ci, eo, ec, s);
        wait_done(s, amt, disturb);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'(Out), 32'd0);
        chk("rst_c", 32'(C), 32'd0);
        chk("rst_z", 32'(Z), 32'd1);
        chk("rst_n_flag", 32'(N), 32'd0);
        chk("rst_p", 32'(P), 32'd1);
    endtask

    initial begin
        int s;
        int s2;
        // Carry persists from row to row.
        vecs[0]  = '{3'b000, 16'h8001, 5'd1,  1'b0, 1'b0, 16'h0002, 1'b1};
        vecs[1]  = '{3'b011, 16'h8000, 5'd4,  1'b0, 1'b0, 16'hF800, 1'b0};
        vecs[2]  = '{3'b001, 16'hFFFF, 5'd20, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{3'b110, 16'h0000, 5'd1,  1'b1, 1'b1, 16'h0001, 1'b0};
        vecs[4]  = '{3'b110, 16'h1234, 5'd17, 1'b0, 1'b0, 16'h1234, 1'b0};
        vecs[5]  = '{3'b101, 16'h0001, 5'd1,  1'b0, 1'b0, 16'h8000, 1'b1};
        vecs[6]  = '{3'b100, 16'h00F0, 5'd0,  1'b0, 1'b0, 16'h00F0, 1'b1};
        vecs[7]  = '{3'b111, 16'h0001, 5'd1,  1'b0, 1'b0, 16'h8000, 1'b1};
        vecs[8]  = '{3'b010, 16'h4000, 5'd2,  1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[9]  = '{3'b100, 16'h8001, 5'd3,  1'b0, 1'b0, 16'h000C, 1'b0};
        vecs[10] = '{3'b011, 16'h8001, 5'd31, 1'b0, 1'b0, 16'hFFFF, 1'b1};
        vecs[11] = '{3'b111, 16'h1234, 5'd17, 1'b0, 1'b0, 16'h1234, 1'b1};
        vecs[12] = '{3'b001, 16'h0003, 5'd2,  1'b1, 1'b0, 16'h0000, 1'b1};

        rst_n = 1'b0; start = 1'b0; A = '0; F = '0; Amt = '0; c_load = 1'b0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].f, vecs[i].a, vecs[i].amt, vecs[i].cl, vecs[i].ci,
                   vecs[i].eo, vecs[i].ec, 1'b0);

        // Stand-alone carry load: C changes, nothing else does.
        @(negedge clk);
        c_load = 1'b1; c_in = 1'b0;
        @(negedge clk);
        c_load = 1'b0;
        #1;
        chk("cload0_c", 32'(C), 32'd0);
        @(negedge clk);
        c_load = 1'b1; c_in = 1'b1;
        @(negedge clk);
        c_load = 1'b0;
        #1;
        chk("cload1_c", 32'(C), 32'd1);
        chk("cload_out", 32'(Out), 32'h0000);
        chk("cload_done", 32'(done), 32'd0);
        run_op(3'b110, 16'h0000, 5'd1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);

        // Start/c_load while busy must be ignored.
        run_op(3'b000, 16'h0001, 5'd8, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Back-to-back: second start in the done cycle of the first.
        @(negedge clk);
        issue(3'b101, 16'h0003, 5'd2, 1'b0, 1'b0, 16'hC000, 1'b1, s);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        issue(3'b110, 16'h0000, 5'd1, 1'b0, 1'b0, 16'h0001, 1'b0, s2);
        wait_done(s2, 5'd1, 1'b0);

        // Asynchronous reset mid-shift: immediate reset values, no late done.
        @(negedge clk);
        issue(3'b001, 16'hFFFF, 5'd10, 1'b0, 1'b0, 16'h003F, 1'b1, s);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 4) @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        run_op(3'b000, 16'h8001, 5'd1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
